// File: rtl/xor_train_scheduler_pkg.sv
// rtl/xor_train_scheduler_pkg.sv - shared types and constants for the XOR training scheduler
package xor_train_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FWD_START,
      ST_FWD_WAIT,
      ST_BP_START,
      ST_BP_WAIT,
      ST_NEXT_SAMPLE,
      ST_FINISH,
      ST_ERROR
   } state_t;

   localparam int PARAM_W    = 16;
   localparam int NUM_PARAMS = 9;
   localparam int TABLE_W    = NUM_PARAMS * PARAM_W;

   localparam logic [3:0] IDX_W11 = 4'd0;
   localparam logic [3:0] IDX_W12 = 4'd1;
   localparam logic [3:0] IDX_W21 = 4'd2;
   localparam logic [3:0] IDX_W22 = 4'd3;
   localparam logic [3:0] IDX_W31 = 4'd4;
   localparam logic [3:0] IDX_W32 = 4'd5;
   localparam logic [3:0] IDX_B1  = 4'd6;
   localparam logic [3:0] IDX_B2  = 4'd7;
   localparam logic [3:0] IDX_B3  = 4'd8;

   localparam logic [15:0] ONE         = 16'h0100;
   localparam logic [1:0]  LAST_SAMPLE = 2'd3;

   // Sample i lives at bits [16i+15:16i] of each ROM column.
   localparam logic [63:0] ROM_X1     = {ONE, ONE, 16'h0000, 16'h0000};
   localparam logic [63:0] ROM_X2     = {ONE, 16'h0000, ONE, 16'h0000};
   localparam logic [63:0] ROM_TARGET = {16'h0000, ONE, ONE, 16'h0000};

   function automatic logic [15:0] rom_field(input logic [63:0] rom, input logic [1:0] idx);
      return rom[{idx, 4'b0000} +: 16];
   endfunction

endpackage

// File: rtl/xor_param_table.sv
// rtl/xor_param_table.sv - 9x16 parameter register file with config write, bulk load and packed read
module xor_param_table
   import xor_train_scheduler_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_en,
   input  logic [3:0]         wr_addr,
   input  logic [15:0]        wr_data,
   input  logic               load_en,
   input  logic [TABLE_W-1:0] load_data,
   output logic [TABLE_W-1:0] table_flat
);

   logic [PARAM_W-1:0] regs [NUM_PARAMS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PARAMS; i++) regs[i] <= '0;
      end else if (load_en) begin
         for (int i = 0; i < NUM_PARAMS; i++) regs[i] <= load_data[PARAM_W*i +: PARAM_W];
      end else if (wr_en && (wr_addr < 4'(NUM_PARAMS))) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      table_flat = '0;
      for (int i = 0; i < NUM_PARAMS; i++) table_flat[PARAM_W*i +: PARAM_W] = regs[i];
   end

endmodule

// File: rtl/xor_train_scheduler.sv
// rtl/xor_train_scheduler.sv - sequences forward/backprop handshakes over the 4-sample XOR set
module xor_train_scheduler
   import xor_train_scheduler_pkg::*;
#(
   parameter int MAX_EPOCH = 1000,
   parameter int TIMEOUT   = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               cfg_we,
   input  logic [3:0]         cfg_addr,
   input  logic [15:0]        cfg_wdata,
   output logic               fwd_start,
   output logic [15:0]        fwd_x1,
   output logic [15:0]        fwd_x2,
   input  logic               fwd_done,
   input  logic [15:0]        fwd_h1,
   input  logic [15:0]        fwd_h2,
   input  logic [15:0]        fwd_y,
   output logic               bp_enable,
   output logic [15:0]        bp_target,
   output logic [15:0]        bp_h1,
   output logic [15:0]        bp_h2,
   output logic [15:0]        bp_y,
   input  logic               bp_weight_valid,
   input  logic               bp_done,
   input  logic [TABLE_W-1:0] bp_w_in,
   output logic [TABLE_W-1:0] w_out,
   output logic               busy,
   output logic               train_done,
   output logic               converged,
   output logic               timeout_err,
   output logic [15:0]        epoch_cnt,
   output logic [1:0]         sample_idx
);

   localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT - 1);
   localparam logic [16:0] EPOCH_LIMIT = 17'(MAX_EPOCH);

   state_t      state, state_n;
   logic [15:0] wait_cnt;
   logic [2:0]  conv_cnt;
   logic [15:0] epoch_next;
   logic        enter_wait;
   logic        table_load;
   logic        cfg_en;

   assign epoch_next = (epoch_cnt == 16'hFFFF) ? epoch_cnt : epoch_cnt + 16'd1;
   assign enter_wait = (state_n != state) && ((state_n == ST_FWD_WAIT) || (state_n == ST_BP_WAIT));
   assign table_load = (state == ST_BP_WAIT) && bp_weight_valid && !abort && !bp_done;
   assign cfg_en     = cfg_we && (state == ST_IDLE);

   assign fwd_x1    = rom_field(ROM_X1, sample_idx);
   assign fwd_x2    = rom_field(ROM_X2, sample_idx);
   assign bp_target = rom_field(ROM_TARGET, sample_idx);

   always_comb begin
      state_n   = state;
      fwd_start = 1'b0;
      bp_enable = 1'b0;
      busy      = (state != ST_IDLE);
      case (state)
         ST_IDLE:      if (start) state_n = ST_FWD_START;
         ST_FWD_START: begin
            fwd_start = 1'b1;
            state_n   = ST_FWD_WAIT;
         end
         ST_FWD_WAIT: begin
            if (fwd_done)                   state_n = ST_BP_START;
            else if (wait_cnt == WAIT_LAST) state_n = ST_ERROR;
         end
         ST_BP_START: begin
            bp_enable = 1'b1;
            state_n   = ST_BP_WAIT;
         end
         ST_BP_WAIT: begin
            if (bp_weight_valid)            state_n = ST_NEXT_SAMPLE;
            else if (wait_cnt == WAIT_LAST) state_n = ST_ERROR;
         end
         ST_NEXT_SAMPLE: begin
            if (sample_idx != LAST_SAMPLE)                       state_n = ST_FWD_START;
            else if (conv_cnt == 3'd4)                           state_n = ST_FINISH;
            else if (({1'b0, epoch_cnt} + 17'd1) == EPOCH_LIMIT) state_n = ST_FINISH;
            else                                                 state_n = ST_FWD_START;
         end
         ST_FINISH:    state_n = ST_IDLE;
         ST_ERROR:     if (!start) state_n = ST_IDLE;
         default:      state_n = ST_IDLE;
      endcase
      // abort wins over any handshake seen in the same cycle
      if (abort && (state != ST_IDLE) && (state != ST_FINISH)) state_n = ST_FINISH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= '0;
         conv_cnt    <= '0;
         epoch_cnt   <= '0;
         sample_idx  <= '0;
         train_done  <= 1'b0;
         converged   <= 1'b0;
         timeout_err <= 1'b0;
         bp_h1       <= '0;
         bp_h2       <= '0;
         bp_y        <= '0;
      end else begin
         if (enter_wait)
            wait_cnt <= '0;
         else if ((state == ST_FWD_WAIT) || (state == ST_BP_WAIT))
            wait_cnt <= wait_cnt + 16'd1;
         if ((state_n == ST_ERROR) && (state != ST_ERROR)) timeout_err <= 1'b1;
         case (state)
            ST_IDLE: if (start) begin
               epoch_cnt   <= '0;
               sample_idx  <= '0;
               conv_cnt    <= '0;
               train_done  <= 1'b0;
               converged   <= 1'b0;
               timeout_err <= 1'b0;
            end
            ST_FWD_WAIT: if (fwd_done && !abort) begin
               bp_h1 <= fwd_h1;
               bp_h2 <= fwd_h2;
               bp_y  <= fwd_y;
            end
            ST_BP_WAIT: if (bp_weight_valid && !abort && bp_done) conv_cnt <= conv_cnt + 3'd1;
            ST_NEXT_SAMPLE: if (!abort) begin
               if (sample_idx != LAST_SAMPLE) begin
                  sample_idx <= sample_idx + 2'd1;
               end else begin
                  sample_idx <= '0;
                  epoch_cnt  <= epoch_next;
                  if (conv_cnt == 3'd4) converged <= 1'b1;
                  else                  conv_cnt  <= '0;
               end
            end
            ST_FINISH: train_done <= 1'b1;
            default: ;
         endcase
      end
   end

   xor_param_table u_table (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (cfg_en),
      .wr_addr    (cfg_addr),
      .wr_data    (cfg_wdata),
      .load_en    (table_load),
      .load_data  (bp_w_in),
      .table_flat (w_out)
   );

endmodule

// File: tb/tb_xor_train_scheduler.sv
// tb/tb_xor_train_scheduler.sv - self-checking bench for xor_train_scheduler
module tb_xor_train_scheduler;

   localparam int TIMEOUT = 64;
   localparam logic [15:0] SX1 [4] = '{16'd0, 16'd0, 16'd256, 16'd256};
   localparam logic [15:0] SX2 [4] = '{16'd0, 16'd256, 16'd0, 16'd256};
   localparam logic [15:0] STG [4] = '{16'd0, 16'd256, 16'd256, 16'd0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start1, start2, abort, cfg_we, fwd_done, bp_weight_valid, bp_done;
   logic [3:0] cfg_addr;
   logic [15:0] cfg_wdata, fwd_h1, fwd_h2, fwd_y;
   logic [143:0] bp_w_in;

   logic fs [2], be [2], bsy [2], td [2], cv [2], te [2];
   logic [15:0] x1 [2], x2 [2], tg [2], h1o [2], h2o [2], yo [2], ep [2];
   logic [1:0] si [2];
   logic [143:0] wo [2];

   int checks = 0;
   int errors = 0;
   int sel = 0;
   int n;
   logic [15:0] mtbl [2][9];
   logic [15:0] ha, hb, hc;
   logic [143:0] snap;

   xor_train_scheduler #(.MAX_EPOCH(1000), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .fwd_start(fs[0]), .fwd_x1(x1[0]), .fwd_x2(x2[0]),
      .fwd_done(fwd_done), .fwd_h1(fwd_h1), .fwd_h2(fwd_h2), .fwd_y(fwd_y),
      .bp_enable(be[0]), .bp_target(tg[0]), .bp_h1(h1o[0]), .bp_h2(h2o[0]), .bp_y(yo[0]),
      .bp_weight_valid(bp_weight_valid), .bp_done(bp_done), .bp_w_in(bp_w_in),
      .w_out(wo[0]), .busy(bsy[0]), .train_done(td[0]), .converged(cv[0]),
      .timeout_err(te[0]), .epoch_cnt(ep[0]), .sample_idx(si[0])
   );

   xor_train_scheduler #(.MAX_EPOCH(2), .TIMEOUT(TIMEOUT)) dut_short (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .fwd_start(fs[1]), .fwd_x1(x1[1]), .fwd_x2(x2[1]),
      .fwd_done(fwd_done), .fwd_h1(fwd_h1), .fwd_h2(fwd_h2), .fwd_y(fwd_y),
      .bp_enable(be[1]), .bp_target(tg[1]), .bp_h1(h1o[1]), .bp_h2(h2o[1]), .bp_y(yo[1]),
      .bp_weight_valid(bp_weight_valid), .bp_done(bp_done), .bp_w_in(bp_w_in),
      .w_out(wo[1]), .busy(bsy[1]), .train_done(td[1]), .converged(cv[1]),
      .timeout_err(te[1]), .epoch_cnt(ep[1]), .sample_idx(si[1])
   );

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [143:0] pack(input int s);
      logic [143:0] v;
      for (int k = 0; k < 9; k++) v[16*k +: 16] = mtbl[s][k];
      return v;
   endfunction

   function automatic logic sig(input int which);
      case (which)
         0:       return fs[sel];
         1:       return be[sel];
         default: return td[sel];
      endcase
   endfunction

   task automatic wait_high(input int which, input string tag);
      int cnt = 0;
      while (!sig(which) && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      chk(tag, 144'(sig(which)), 144'(1));
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic rand_weights();
      for (int k = 0; k < 9; k++) bp_w_in[16*k +: 16] = 16'($urandom);
   endtask

   // One sample exchange acting as forward and backprop units.
   task automatic serve(input int s, input int exp_epoch, input bit done);
      logic [15:0] a, b, c;
      wait_high(0, "fwd_start");
      chk("sample_idx", 144'(si[sel]), 144'(s));
      chk("epoch_cnt_run", 144'(ep[sel]), 144'(exp_epoch));
      chk("fwd_x1", 144'(x1[sel]), 144'(SX1[s]));
      chk("fwd_x2", 144'(x2[sel]), 144'(SX2[s]));
      @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      fwd_h1 = a; fwd_h2 = b; fwd_y = c; fwd_done = 1'b1;
      @(negedge clk);
      fwd_done = 1'b0; fwd_h1 = ~a; fwd_h2 = ~b; fwd_y = ~c;
      wait_high(1, "bp_enable");
      chk("bp_h1", 144'(h1o[sel]), 144'(a));
      chk("bp_h2", 144'(h2o[sel]), 144'(b));
      chk("bp_y", 144'(yo[sel]), 144'(c));
      chk("bp_target", 144'(tg[sel]), 144'(STG[s]));
      @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rand_weights();
      bp_done = done; bp_weight_valid = 1'b1;
      @(negedge clk);
      bp_weight_valid = 1'b0; bp_done = 1'b0;
      if (!done) for (int k = 0; k < 9; k++) mtbl[sel][k] = bp_w_in[16*k +: 16];
      chk("w_out_after_bp", wo[sel], pack(sel));
   endtask

   // An epoch converges only when every sample reports done.
   task automatic train(input int max_ep, input int conv_ep);
      logic [3:0] flags;
      bit fin;
      int e;
      if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      e = 1; fin = 1'b0; flags = 4'h0;
      while (!fin) begin
         if (e == conv_ep)  flags = 4'hF;
         else if (e == 1)   flags = 4'h0;
         else               flags = 4'($urandom_range(0, 14));
         for (int s = 0; s < 4; s++) serve(s, e - 1, flags[s]);
         fin = (flags == 4'hF) || (e == max_ep);
         if (!fin) e++;
      end
      wait_high(2, "train_done");
      chk("converged", 144'(cv[sel]), 144'(flags == 4'hF));
      chk("epoch_final", 144'(ep[sel]), 144'(e));
      chk("busy_after", 144'(bsy[sel]), 144'(0));
      chk("sample_idx_after", 144'(si[sel]), 144'(0));
      chk("w_out_final", wo[sel], pack(sel));
   endtask

   initial begin
      rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; abort = 1'b0; cfg_we = 1'b0;
      cfg_addr = '0; cfg_wdata = '0; fwd_done = 1'b0; fwd_h1 = '0; fwd_h2 = '0; fwd_y = '0;
      bp_weight_valid = 1'b0; bp_done = 1'b0; bp_w_in = '0;
      for (int s = 0; s < 2; s++) for (int k = 0; k < 9; k++) mtbl[s][k] = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 144'(bsy[0]), 144'(0));
      chk("rst_w_out", wo[0], 144'(0));
      chk("rst_flags", 144'({td[0], cv[0], te[0], fs[0], be[0]}), 144'(0));
      chk("rst_epoch", 144'(ep[0]), 144'(0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 9; k++) begin
         cfg_write(4'(k), 16'($urandom));
         mtbl[0][k] = cfg_wdata; mtbl[1][k] = cfg_wdata;
      end
      chk("cfg_fill", wo[0], pack(0));
      cfg_write(4'd4, 16'h0180);
      mtbl[0][4] = 16'h0180; mtbl[1][4] = 16'h0180;
      chk("cfg_addr4", 144'(wo[0][79:64]), 144'(16'h0180));
      for (int a = 9; a < 16; a++) cfg_write(4'(a), 16'($urandom));
      chk("cfg_bad_addr", wo[0], pack(0));

      rand_weights();
      fwd_done = 1'b1; bp_weight_valid = 1'b1;
      @(negedge clk);
      fwd_done = 1'b0; bp_weight_valid = 1'b0;
      chk("idle_hs_ignored", wo[0], pack(0));
      chk("idle_busy", 144'(bsy[0]), 144'(0));

      sel = 0;
      train(1000, 3);
      sel = 1;
      train(2, 0);

      sel = 0;
      start1 = 1'b1;
      wait_high(0, "to_fwd_start");
      chk("start_clears_done", 144'(td[0]), 144'(0));
      @(negedge clk);
      snap = wo[0];
      cfg_write(4'd4, 16'h0180 ^ wo[0][79:64]);
      mtbl[1][4] = cfg_wdata;
      chk("cfg_busy_ignored", wo[0], snap);
      n = 2;
      while (!te[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", 144'(n), 144'(TIMEOUT + 1));
      @(negedge clk);
      chk("error_hold_busy", 144'(bsy[0]), 144'(1));
      start1 = 1'b0;
      @(negedge clk);
      chk("error_to_idle", 144'(bsy[0]), 144'(0));
      chk("timeout_err_held", 144'(te[0]), 144'(1));

      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_high(0, "ab_fwd_start");
      chk("start_clears_to", 144'(te[0]), 144'(0));
      @(negedge clk);
      fwd_done = 1'b1;
      @(negedge clk);
      fwd_done = 1'b0;
      wait_high(1, "ab_bp_enable");
      @(negedge clk);
      snap = wo[0];
      rand_weights();
      bp_done = 1'b0; bp_weight_valid = 1'b1; abort = 1'b1;
      @(negedge clk);
      bp_weight_valid = 1'b0; abort = 1'b0;
      chk("abort_table", wo[0], snap);
      chk("abort_finish_busy", 144'(bsy[0]), 144'(1));
      @(negedge clk);
      chk("abort_done", 144'(td[0]), 144'(1));
      chk("abort_conv", 144'(cv[0]), 144'(0));
      chk("abort_idle", 144'(bsy[0]), 144'(0));

      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_high(0, "rst_fwd_start");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 144'(bsy[0]), 144'(0));
      chk("midrst_table", wo[0], 144'(0));
      chk("midrst_done", 144'(td[0]), 144'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xor_train_scheduler.md
XOR_TRAIN_SCHEDULER -- requirements
Module: xor_train_scheduler

Interface
REQ-001 Parameter MAX_EPOCH, default 1000: epoch limit before forced stop.
REQ-002 Parameter TIMEOUT, default 64: max cycles to wait for any handshake return.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  level; sampled only in IDLE; begins training.
REQ-007 abort  in  1  synchronous; forces FINISH from any non-IDLE state.
REQ-008 cfg_we/cfg_addr/cfg_wdata  in  1/4/16  weight-table write port.
REQ-009 fwd_start  out  1  one-cycle pulse to forward unit.
REQ-010 fwd_x1, fwd_x2  out  16 each  current sample inputs, 8.8 signed.
REQ-011 fwd_done  in  1  forward result valid pulse; fwd_h1/fwd_h2/fwd_y  in  16 each.
REQ-012 bp_enable  out  1  one-cycle pulse to backprop unit; bp_target  out  16.
REQ-013 bp_weight_valid  in  1  backprop completion pulse; bp_done  in  1  error-below-threshold flag.
REQ-014 bp_w_in  in  144  updated parameters from backprop, packed per REQ-017.
REQ-015 w_out  out  144  current parameter table, packed per REQ-017.
REQ-016 busy, train_done, converged, timeout_err  out  1 each; epoch_cnt  out  16; sample_idx  out  2.

Function
REQ-017 Table order, index 0..8 = w11,w12,w21,w22,w31,w32,b1,b2,b3; index k occupies w_out[16k+15:16k].
REQ-018 cfg writes accepted only in IDLE; cfg_addr>8 or non-IDLE writes ignored; written value visible on w_out next cycle.
REQ-019 Sample ROM (x1,x2,target): 0=(0,0,0), 1=(0,256,256), 2=(256,0,256), 3=(256,256,0); fwd_x1/fwd_x2/bp_target driven from ROM[sample_idx] continuously.
REQ-020 States: IDLE, FWD_START, FWD_WAIT, BP_START, BP_WAIT, NEXT_SAMPLE, FINISH, ERROR.
REQ-021 IDLE & start: clear epoch_cnt, sample_idx, conv_cnt, train_done, converged, timeout_err; go FWD_START.
REQ-022 FWD_START: assert fwd_start one cycle; go FWD_WAIT.
REQ-023 FWD_WAIT: on fwd_done, latch fwd_h1/fwd_h2/fwd_y (held stable to backprop until next FWD_WAIT); go BP_START.
REQ-024 BP_START: assert bp_enable one cycle; go BP_WAIT.
REQ-025 BP_WAIT on bp_weight_valid: if bp_done=1, increment conv_cnt, table unchanged; else load bp_w_in into table, conv_cnt unchanged; go NEXT_SAMPLE.
REQ-026 NEXT_SAMPLE: sample_idx<3 -> increment, go FWD_START; sample_idx=3 -> sample_idx=0, epoch_cnt+1; if conv_cnt=4 set converged, go FINISH; elif epoch_cnt+1=MAX_EPOCH go FINISH; else clear conv_cnt, go FWD_START.
REQ-027 NEXT_SAMPLE guarantees at least 2 cycles between bp_weight_valid and next bp_enable.
REQ-028 Wait counter clears on entry to FWD_WAIT/BP_WAIT, increments each waiting cycle; reaching TIMEOUT -> ERROR, timeout_err=1.
REQ-029 FINISH: train_done=1 one cycle after entry; go IDLE; train_done, converged held until next start.
REQ-030 ERROR: hold until start=0, then IDLE; timeout_err held until next start.
REQ-031 abort has priority over handshake inputs in same cycle; pending bp_weight_valid in that cycle is discarded.
REQ-032 busy=1 in every state except IDLE.
REQ-033 epoch_cnt saturates at 16'hFFFF; no wrap.
REQ-034 fwd_done outside FWD_WAIT and bp_weight_valid outside BP_WAIT ignored.

Reset
REQ-035 rst_n low: state IDLE; all outputs 0; table, latches, counters 0.
REQ-036 Reset mid-operation abandons training; no partial table update survives.

Structure
REQ-037 Shared package holds state encoding, table index constants, sample ROM constants, 8.8 ONE=256.
REQ-038 One sub-module natural: xor_param_table (9x16 register file, cfg write, bulk load, packed read).

Verification
REQ-039 cfg write addr 4 = 16'h0180 in IDLE -> w_out[79:64]=16'h0180 next cycle; same write while busy -> unchanged.
REQ-040 start, model returns bp_done=0 every sample -> 4 fwd_start/bp_enable pairs per epoch, sample_idx 0,1,2,3,0, table reloaded each sample, epoch_cnt=1.
REQ-041 model returns bp_done=1 all four samples of epoch 3 -> converged=1, train_done=1, epoch_cnt=3, busy=0.
REQ-042 MAX_EPOCH=2, never converge -> train_done=1, converged=0, epoch_cnt=2.
REQ-043 fwd_done withheld -> timeout_err=1 after TIMEOUT=64 cycles in FWD_WAIT; IDLE after start deasserts.
REQ-044 abort in BP_WAIT coincident with bp_weight_valid -> table unchanged, FINISH then IDLE, converged=0.
